// File: rtl/spram_arb_pkg.sv
// Shared types for the SPRAM arbiter: FSM state encoding, owner IDs and
// the width of the DMA starvation counter.
package spram_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK_CPU = 2'd1,
    ACK_DMA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/spram_arbiter.sv
// Shares one single-port SPRAM between the CPU bus and a DMA master.
// Each access takes an issue cycle followed by an ACK cycle. An ACK cycle
// may issue the other requester, so alternating traffic runs at one access
// per cycle. The CPU wins contention unless the DMA has lost MAX_WAIT times
// in a row.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 16
) (
  input  logic          clk24,
  input  logic          reset,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_valid,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  input  logic [3:0]    dma_wstrb,
  output logic [31:0]   dma_rdata,
  output logic          dma_ready,
  output logic          ram_sel,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdat,
  input  logic [31:0]   ram_rdat,
  output logic          dma_starved
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_t            grant;

  // Grant: the requester that issued last cycle is masked; CPU wins ties
  // unless the starvation counter has reached its limit. Reset blocks issue.
  always_comb begin
    grant       = OWN_NONE;
    dma_starved = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_valid && dma_valid) begin
          if (wait_cnt_q == MAX_CNT) begin
            grant       = OWN_DMA;
            dma_starved = 1'b1;
          end else begin
            grant = OWN_CPU;
          end
        end else if (cpu_valid) begin
          grant = OWN_CPU;
        end else if (dma_valid) begin
          grant = OWN_DMA;
        end
      end
      ACK_CPU: if (dma_valid) grant = OWN_DMA;
      ACK_DMA: if (cpu_valid) grant = OWN_CPU;
      default: grant = OWN_NONE;
    endcase
    if (reset) begin
      grant       = OWN_NONE;
      dma_starved = 1'b0;
    end
  end

  // Next state and starvation counter follow the grant made this cycle.
  always_comb begin
    state_d    = IDLE;
    wait_cnt_d = wait_cnt_q;
    case (grant)
      OWN_CPU: begin
        state_d = ACK_CPU;
        if (dma_valid && (wait_cnt_q < MAX_CNT)) wait_cnt_d = wait_cnt_q + 1'b1;
      end
      OWN_DMA: begin
        state_d    = ACK_DMA;
        wait_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // SPRAM side: the winner drives address, data and strobes; idle muxes
  // rest on the CPU port with write enables held low.
  always_comb begin
    ram_sel  = (grant != OWN_NONE);
    ram_addr = cpu_addr;
    ram_wdat = cpu_wdata;
    ram_we   = 4'b0000;
    if (grant == OWN_DMA) begin
      ram_addr = dma_addr;
      ram_wdat = dma_wdata;
      ram_we   = dma_wstrb;
    end else if (grant == OWN_CPU) begin
      ram_we = cpu_wstrb;
    end
  end

  // Ready pulses come straight from the registered state; an ACK that is
  // interrupted by reset is dropped.
  always_comb begin
    cpu_ready = !reset && (state_q == ACK_CPU);
    dma_ready = !reset && (state_q == ACK_DMA);
    cpu_rdata = ram_rdat;
    dma_rdata = ram_rdat;
  end

  // State and starvation counter registers, synchronous reset.
  always_ff @(posedge clk24) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a small behavioural SPRAM model.
module tb_spram_arbiter;

  logic        clk24 = 1'b0;
  logic        reset;
  logic        cpu_valid, dma_valid;
  logic [15:0] cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic [3:0]  cpu_wstrb, dma_wstrb;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ready, dma_ready;
  logic        ram_sel;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdat;
  logic [31:0] ram_rdat = 32'h0;
  logic        dma_starved;

  logic [31:0] mem [0:1023];
  int compared   = 0;
  int mismatched = 0;

  spram_arbiter #(.MAX_WAIT(4), .AW(16)) dut (
    .clk24(clk24), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdat(ram_wdat), .ram_rdat(ram_rdat), .dma_starved(dma_starved)
  );

  always #5 clk24 = ~clk24;

  // SPRAM model: registered read of the old word, byte-masked write.
  always @(posedge clk24) begin
    if (ram_sel) begin
      ram_rdat <= mem[ram_addr[11:2]];
      if (ram_we[0]) mem[ram_addr[11:2]][7:0]   <= ram_wdat[7:0];
      if (ram_we[1]) mem[ram_addr[11:2]][15:8]  <= ram_wdat[15:8];
      if (ram_we[2]) mem[ram_addr[11:2]][23:16] <= ram_wdat[23:16];
      if (ram_we[3]) mem[ram_addr[11:2]][31:24] <= ram_wdat[31:24];
    end
  end

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_valid = 1'b1; dma_valid = 1'b1;
    cpu_wstrb = 4'hF; dma_wstrb = 4'hF;
    @(negedge clk24);
    compared++; if (ram_sel !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sel: got %b want 0", ram_sel); end
    compared++; if (ram_we !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_we: got %h want 0", ram_we); end
    compared++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b%b want 00", cpu_ready, dma_ready); end
    compared++; if (dma_starved !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_starved: got %b want 0", dma_starved); end
    tick();
    compared++; if (dut.state_q !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d want 0", dut.state_q); end
    compared++; if (dut.wait_cnt_q !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_wait: got %0d want 0", dut.wait_cnt_q); end
    reset = 1'b0; cpu_valid = 1'b0; dma_valid = 1'b0;
    cpu_wstrb = 4'h0; dma_wstrb = 4'h0;
  endtask

  task automatic test_cpu_read();
    mem[4] = 32'hDEADBEEF;
    tick();
    cpu_valid = 1'b1; cpu_addr = 16'h0010; cpu_wstrb = 4'h0;
    @(negedge clk24);
    compared++; if (ram_sel !== 1'b1 || ram_addr !== 16'h0010) begin mismatched++; $display("[TB] FAIL cpu_issue: sel=%b addr=%h want 1/0010", ram_sel, ram_addr); end
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL cpu_early_ready: got %b want 0", cpu_ready); end
    tick();
    @(negedge clk24);
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL cpu_ready: got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL cpu_rdata: got %h want deadbeef", cpu_rdata); end
    compared++; if (dma_ready !== 1'b0 || ram_sel !== 1'b0) begin mismatched++; $display("[TB] FAIL cpu_mask: dma_ready=%b sel=%b want 0/0", dma_ready, ram_sel); end
    tick();
    cpu_valid = 1'b0;
    @(negedge clk24);
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL cpu_ready_once: got %b want 0", cpu_ready); end
  endtask

  task automatic test_simultaneous();
    mem[8] = 32'hCAFEF00D;
    tick();
    cpu_valid = 1'b1; cpu_addr = 16'h0010;
    dma_valid = 1'b1; dma_addr = 16'h0020; dma_wstrb = 4'h0;
    @(negedge clk24);
    compared++; if (ram_addr !== 16'h0010 || dma_starved !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_cpu_first: addr=%h starved=%b want 0010/0", ram_addr, dma_starved); end
    tick();
    @(negedge clk24);
    compared++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL sim_cpu_ready: rdy=%b data=%h want 1/deadbeef", cpu_ready, cpu_rdata); end
    compared++; if (ram_sel !== 1'b1 || ram_addr !== 16'h0020) begin mismatched++; $display("[TB] FAIL sim_dma_issue: sel=%b addr=%h want 1/0020", ram_sel, ram_addr); end
    compared++; if (dut.wait_cnt_q !== 4'd1) begin mismatched++; $display("[TB] FAIL sim_wait1: got %0d want 1", dut.wait_cnt_q); end
    tick();
    cpu_valid = 1'b0;
    @(negedge clk24);
    compared++; if (dma_ready !== 1'b1 || dma_rdata !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL sim_dma_ready: rdy=%b data=%h want 1/cafef00d", dma_ready, dma_rdata); end
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_cpu_quiet: got %b want 0", cpu_ready); end
    compared++; if (dut.wait_cnt_q !== 4'd0) begin mismatched++; $display("[TB] FAIL sim_wait0: got %0d want 0", dut.wait_cnt_q); end
    tick();
    dma_valid = 1'b0;
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 4; k++) begin
      tick();
      cpu_valid = 1'b1; cpu_addr = 16'h0010;
      dma_valid = 1'b1; dma_addr = 16'h0020;
      @(negedge clk24);
      compared++; if (ram_addr !== 16'h0010 || dma_starved !== 1'b0) begin mismatched++; $display("[TB] FAIL starve_cpu%0d: addr=%h starved=%b want 0010/0", k, ram_addr, dma_starved); end
      tick();
      cpu_valid = 1'b0; dma_valid = 1'b0;
      @(negedge clk24);
      compared++; if (cpu_ready !== 1'b1 || dut.wait_cnt_q !== 4'(k + 1)) begin mismatched++; $display("[TB] FAIL starve_cnt%0d: rdy=%b cnt=%0d want 1/%0d", k, cpu_ready, dut.wait_cnt_q, k + 1); end
    end
    tick();
    cpu_valid = 1'b1; dma_valid = 1'b1;
    @(negedge clk24);
    compared++; if (ram_sel !== 1'b1 || ram_addr !== 16'h0020 || dma_starved !== 1'b1) begin mismatched++; $display("[TB] FAIL starve_force: sel=%b addr=%h starved=%b want 1/0020/1", ram_sel, ram_addr, dma_starved); end
    tick();
    cpu_valid = 1'b0; dma_valid = 1'b0;
    @(negedge clk24);
    compared++; if (dma_ready !== 1'b1 || dma_starved !== 1'b0) begin mismatched++; $display("[TB] FAIL starve_ack: rdy=%b starved=%b want 1/0", dma_ready, dma_starved); end
    compared++; if (dut.wait_cnt_q !== 4'd0) begin mismatched++; $display("[TB] FAIL starve_clear: got %0d want 0", dut.wait_cnt_q); end
  endtask

  task automatic test_byte_write();
    mem[64] = 32'h11223344;
    tick();
    dma_valid = 1'b1; dma_addr = 16'h0100; dma_wstrb = 4'b0100; dma_wdata = 32'h00AB0000;
    @(negedge clk24);
    compared++; if (ram_we !== 4'b0100 || ram_wdat !== 32'h00AB0000 || ram_addr !== 16'h0100) begin mismatched++; $display("[TB] FAIL bw_issue: we=%b wdat=%h addr=%h want 0100/00ab0000/0100", ram_we, ram_wdat, ram_addr); end
    tick();
    dma_valid = 1'b0; dma_wstrb = 4'h0;
    cpu_valid = 1'b1; cpu_addr = 16'h0100; cpu_wstrb = 4'h0;
    @(negedge clk24);
    compared++; if (dma_ready !== 1'b1 || ram_we !== 4'h0 || ram_sel !== 1'b1) begin mismatched++; $display("[TB] FAIL bw_ack: rdy=%b we=%b sel=%b want 1/0000/1", dma_ready, ram_we, ram_sel); end
    tick();
    cpu_valid = 1'b0;
    @(negedge clk24);
    compared++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h11AB3344) begin mismatched++; $display("[TB] FAIL bw_readback: rdy=%b data=%h want 1/11ab3344", cpu_ready, cpu_rdata); end
  endtask

  task automatic test_reset_mid();
    tick();
    cpu_valid = 1'b1; cpu_addr = 16'h0010;
    dma_valid = 1'b1; dma_addr = 16'h0020; dma_wstrb = 4'hF;
    @(negedge clk24);
    compared++; if (ram_sel !== 1'b1 || ram_addr !== 16'h0010) begin mismatched++; $display("[TB] FAIL rm_issue: sel=%b addr=%h want 1/0010", ram_sel, ram_addr); end
    tick();
    reset = 1'b1;
    @(negedge clk24);
    compared++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_ready: got %b%b want 00", cpu_ready, dma_ready); end
    compared++; if (ram_sel !== 1'b0 || ram_we !== 4'h0) begin mismatched++; $display("[TB] FAIL rm_ram: sel=%b we=%b want 0/0000", ram_sel, ram_we); end
    compared++; if (dut.wait_cnt_q !== 4'd1) begin mismatched++; $display("[TB] FAIL rm_wait_pre: got %0d want 1", dut.wait_cnt_q); end
    tick();
    reset = 1'b0; cpu_valid = 1'b0; dma_valid = 1'b0; dma_wstrb = 4'h0;
    @(negedge clk24);
    compared++; if (dut.state_q !== 2'd0 || dut.wait_cnt_q !== 4'd0) begin mismatched++; $display("[TB] FAIL rm_after: state=%0d cnt=%0d want 0/0", dut.state_q, dut.wait_cnt_q); end
    compared++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_no_pulse: got %b%b want 00", cpu_ready, dma_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      tick();
      cpu_valid = 1'b1; cpu_addr = 16'h0010;
      dma_valid = 1'b1; dma_addr = 16'h0020;
      @(negedge clk24);
      compared++; if (ram_sel !== 1'b1 || ram_addr !== ((i % 2 == 0) ? 16'h0010 : 16'h0020)) begin mismatched++; $display("[TB] FAIL b2b_issue%0d: sel=%b addr=%h", i, ram_sel, ram_addr); end
      compared++; if (cpu_ready !== (i % 2 == 1) || dma_ready !== (i >= 2 && i % 2 == 0)) begin mismatched++; $display("[TB] FAIL b2b_ready%0d: cpu=%b dma=%b", i, cpu_ready, dma_ready); end
      compared++; if ((i % 2 == 1) && cpu_rdata !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL b2b_cdata%0d: got %h want deadbeef", i, cpu_rdata); end
      compared++; if ((i >= 2 && i % 2 == 0) && dma_rdata !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL b2b_ddata%0d: got %h want cafef00d", i, dma_rdata); end
    end
    tick();
    cpu_valid = 1'b0; dma_valid = 1'b0;
    @(negedge clk24);
    compared++; if (dma_ready !== 1'b1 || cpu_ready !== 1'b0 || ram_sel !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_tail: dma=%b cpu=%b sel=%b want 1/0/0", dma_ready, cpu_ready, ram_sel); end
    tick();
  endtask

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Test sequence.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    cpu_addr = 16'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    dma_addr = 16'h0; dma_wdata = 32'h0; dma_wstrb = 4'h0;
    cpu_valid = 1'b0; dma_valid = 1'b0; reset = 1'b1;
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_starvation();
    test_byte_write();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
